// File: rtl/mem_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_arbiter : two-master arbiter for the shared memory port, with
//               round-robin or fixed priority and an access watchdog.
// Revision    : 1.0
// ==========================================================================
module mem_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_we,
   input  logic [2:0]  m0_funct3,
   output logic        m0_gnt,
   output logic        m0_valid,
   output logic        m0_err,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_we,
   input  logic [2:0]  m1_funct3,
   output logic        m1_gnt,
   output logic        m1_valid,
   output logic        m1_err,
   output logic [31:0] m1_rdata,

   output logic        mem_ce,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   output logic        mem_memwrite,
   output logic [2:0]  mem_funct3,
   input  logic        mem_busy,
   input  logic        mem_valid,
   input  logic [31:0] mem_dataout
);

   localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [1:0]         r_grant;
   logic               r_last;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_ce;

   logic w_active;
   logic w_sel1;
   logic w_pick_m1;
   logic w_timeout;
   logic w_done;

   assign w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign w_sel1    = r_grant[1];
   // Contested requests go to m0 under fixed priority, else to whoever was not served last.
   assign w_pick_m1 = m1_req && (!m0_req || ((FIXED_PRIO == 0) && !r_last));
   assign w_timeout = (r_cnt == c_CNT_LAST);
   assign w_done    = (r_state == S_WAIT) && (mem_valid || w_timeout);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_grant <= 2'b00;
         r_last  <= 1'b1;
         r_cnt   <= '0;
         r_ce    <= 1'b0;
      end else begin
         r_ce <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if ((m0_req || m1_req) && !mem_busy) begin
                  r_grant <= w_pick_m1 ? 2'b10 : 2'b01;
                  r_ce    <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt != '1) begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
               if (w_done) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_last  <= r_grant[1];
               r_grant <= 2'b00;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The bus carries the owner's request only while an access is in flight.
   assign mem_ce       = r_ce;
   assign mem_addr     = w_active ? (w_sel1 ? m1_addr   : m0_addr)   : 32'h0;
   assign mem_datain   = w_active ? (w_sel1 ? m1_wdata  : m0_wdata)  : 32'h0;
   assign mem_funct3   = w_active ? (w_sel1 ? m1_funct3 : m0_funct3) : 3'b000;
   assign mem_memwrite = w_active && (w_sel1 ? m1_we : m0_we);

   assign m0_gnt   = w_active && r_grant[0];
   assign m1_gnt   = w_active && r_grant[1];
   assign m0_valid = w_done && r_grant[0];
   assign m1_valid = w_done && r_grant[1];
   assign m0_err   = m0_valid && !mem_valid;
   assign m1_err   = m1_valid && !mem_valid;
   assign m0_rdata = (m0_valid && mem_valid) ? mem_dataout : 32'h0;
   assign m1_rdata = (m1_valid && mem_valid) ? mem_dataout : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter : randomized scoreboard bench; instance 0 is round-robin,
// instance 1 is fixed priority, both with an 8-cycle watchdog.
module tb_mem_arbiter;

   localparam int c_TO    = 8;
   localparam int c_RUN   = 2000;
   localparam int c_QUIET = 1800;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      typedef struct {
         int          cyc;
         bit          m;
         bit          err;
         logic [31:0] data;
      } exp_t;

      logic             reset;
      logic [1:0]       req, we;
      logic [1:0][31:0] addr, wdata;
      logic [1:0][2:0]  f3;
      logic [1:0]       gnt, vld, err;
      logic [1:0][31:0] rdata;
      logic             mem_ce, mem_memwrite, mem_busy, mem_valid;
      logic [31:0]      mem_addr, mem_datain, mem_dataout;
      logic [2:0]       mem_funct3;

      // Reference model: one transaction timeline per arbiter.
      exp_t        q[$];
      bit          done = 1'b0;
      bit          have = 1'b0;
      bit          owner = 1'b0;
      bit          last = 1'b1;
      bit          first = 1'b1;
      int          ce_cyc = -100;
      int          end_cyc = -100;
      int          resp_cyc = -100;
      int          late_cyc = -100;
      int          free_from = 0;
      int          rst_until = 0;
      int          next_rst = 250;
      int          done_at[2];
      bit [1:0]    pend;
      logic [31:0] resp_data;
      logic        exp_ce = 1'b0;
      logic [1:0]  exp_gnt = 2'b00;
      logic [67:0] exp_bus = '0;

      mem_arbiter #(.FIXED_PRIO(g), .TIMEOUT(c_TO)) u_dut (
         .clk(clk), .reset(reset),
         .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_we(we[0]),
         .m0_funct3(f3[0]), .m0_gnt(gnt[0]), .m0_valid(vld[0]), .m0_err(err[0]),
         .m0_rdata(rdata[0]),
         .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_we(we[1]),
         .m1_funct3(f3[1]), .m1_gnt(gnt[1]), .m1_valid(vld[1]), .m1_err(err[1]),
         .m1_rdata(rdata[1]),
         .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_datain(mem_datain),
         .mem_memwrite(mem_memwrite), .mem_funct3(mem_funct3), .mem_busy(mem_busy),
         .mem_valid(mem_valid), .mem_dataout(mem_dataout)
      );

      task automatic new_access(input int m);
         req[m]     = 1'b1;
         addr[m]    = $urandom;
         wdata[m]   = $urandom;
         we[m]      = 1'($urandom_range(0, 1));
         f3[m]      = 3'($urandom_range(0, 7));
         pend[m]    = 1'b1;
         done_at[m] = -100;
      endtask

      initial begin : p_stim
         reset = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; f3 = '0;
         mem_busy = 1'b0; mem_valid = 1'b0; mem_dataout = '0; pend = '0;
         done_at[0] = -100; done_at[1] = -100;
         for (int k = 0; k < c_RUN; k++) begin
            int n, len, w;
            bit to, allow, in_wait;
            @(posedge clk); #1;
            n = cyc;
            allow = (n < c_QUIET);
            if (have && n > end_cyc) have = 1'b0;

            // Reset: initial pulse with m0 already requesting, then occasional aborts mid-WAIT.
            if (n == 1) new_access(0);
            if (n >= 4 && !reset && n >= rst_until) begin
               reset = 1'b1;
            end else if (reset && n >= next_rst && have && n > ce_cyc && n <= end_cyc) begin
               reset = 1'b0; rst_until = n + 2; next_rst = n + 250;
               have = 1'b0; q.delete(); resp_cyc = -100; late_cyc = -100;
               free_from = 0; pend = '0; req = '0; last = 1'b1;
            end

            // Masters release or renew in the recovery cycle after completion.
            for (int m = 0; m < 2; m++) begin
               if (pend[m] && n == done_at[m] + 1) begin
                  pend[m] = 1'b0; req[m] = 1'b0;
                  if (allow && $urandom_range(0, 1) == 1) new_access(m);
               end else if (!pend[m] && allow && $urandom_range(0, 3) == 0) begin
                  new_access(m);
               end
            end

            mem_busy = ($urandom_range(0, 4) == 0);

            if (reset && n >= free_from && req != 2'b00 && !mem_busy) begin
               if (req == 2'b11) w = (g == 1) ? 0 : (last ? 0 : 1);
               else              w = req[1] ? 1 : 0;
               len       = first ? 3 : int'($urandom_range(1, c_TO + 3));
               resp_data = first ? 32'hDEADBEEF : $urandom;
               first     = 1'b0;
               to        = (len > c_TO);
               if (resp_cyc > n) late_cyc = resp_cyc;
               owner     = w[0];
               last      = w[0];
               have      = 1'b1;
               ce_cyc    = n + 1;
               end_cyc   = ce_cyc + (to ? c_TO : len);
               resp_cyc  = ce_cyc + len;
               free_from = end_cyc + 2;
               done_at[w] = end_cyc;
               q.push_back('{end_cyc, w[0], to, to ? 32'h0 : resp_data});
            end

            // Memory: scheduled (possibly late) response plus stray pulses outside WAIT.
            in_wait     = have && n > ce_cyc && n <= end_cyc;
            mem_valid   = (n == resp_cyc) || (n == late_cyc) ||
                          (!in_wait && $urandom_range(0, 7) == 0);
            mem_dataout = (n == resp_cyc) ? resp_data : $urandom;

            exp_ce = have && n == ce_cyc;
            if (have && n >= ce_cyc && n <= end_cyc) begin
               exp_gnt = owner ? 2'b10 : 2'b01;
               exp_bus = {addr[owner], wdata[owner], we[owner], f3[owner]};
            end else begin
               exp_gnt = 2'b00;
               exp_bus = '0;
            end
         end
         done = 1'b1;
      end

      always @(negedge clk) begin : p_mon
         exp_t e;
         if (cyc > 0 && !done) begin
            chk($sformatf("ce[%0d]", g), 128'(mem_ce), 128'(exp_ce));
            chk($sformatf("gnt[%0d]", g), 128'(gnt), 128'(exp_gnt));
            chk($sformatf("bus[%0d]", g),
                128'({mem_addr, mem_datain, mem_memwrite, mem_funct3}), 128'(exp_bus));
            if (!reset) chk($sformatf("reset_out[%0d]", g), 128'({vld, err, rdata}), 128'(0));
            if (vld != 2'b00 || (q.size() != 0 && q[0].cyc <= cyc)) begin
               if (q.size() == 0) begin
                  chk($sformatf("unexpected_valid[%0d]", g), 128'(vld), 128'(0));
               end else begin
                  e = q.pop_front();
                  chk($sformatf("resp[%0d]", g),
                      128'({32'(cyc), vld, err[e.m], rdata[e.m]}),
                      128'({32'(e.cyc), (e.m ? 2'b10 : 2'b01), e.err, e.data}));
               end
            end
         end
      end
   end

   initial begin : p_main
      for (int i = 0; i < c_RUN + 100; i++) begin
         if (g_inst[0].done && g_inst[1].done) break;
         @(posedge clk);
      end
      chk("run_complete", 128'({g_inst[1].done, g_inst[0].done}), 128'(2'b11));
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
